// File: rtl/banner_glyph_decoder.sv
// banner_glyph_decoder
// Receive side of the 5-line dot-matrix banner link. Columns arrive one per
// col_valid strobe; four consecutive columns form a 4x5 glyph which is matched
// against a fixed font and reported as ASCII one cycle after the 4th column.
module banner_glyph_decoder #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       line,
    input  logic             col_valid,
    output logic             char_valid,
    output logic [7:0]       char_code,
    output logic             char_err,
    output logic             frame_err,
    output logic [CNT_W-1:0] char_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_GAP     = 2'd2,
        ST_RESYNC  = 2'd3
    } state_t;

    // Font match: glyph is {col0, col1, col2, col3}, col0 in the MSBs.
    // Returns {no_match, ascii}; a miss yields '?'.
    function automatic logic [8:0] font_lookup(input logic [19:0] glyph);
        logic [8:0] res;
        case (glyph)
            {5'h17, 5'h15, 5'h15, 5'h1D}: res = {1'b0, 8'h53}; // S
            {5'h1F, 5'h05, 5'h0D, 5'h12}: res = {1'b0, 8'h52}; // R
            {5'h1F, 5'h15, 5'h15, 5'h11}: res = {1'b0, 8'h45}; // E
            {5'h1F, 5'h04, 5'h0A, 5'h11}: res = {1'b0, 8'h4B}; // K
            {5'h1E, 5'h05, 5'h05, 5'h1E}: res = {1'b0, 8'h41}; // A
            {5'h1F, 5'h02, 5'h04, 5'h1F}: res = {1'b0, 8'h4E}; // N
            {5'h01, 5'h1F, 5'h01, 5'h01}: res = {1'b0, 8'h54}; // T
            {5'h1F, 5'h04, 5'h04, 5'h1F}: res = {1'b0, 8'h48}; // H
            default:                      res = {1'b1, 8'h3F}; // unknown
        endcase
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [19:0]        glyph_q, glyph_d;
    logic [2:0]         col_cnt_q, col_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               match_q, match_d;
    logic               char_valid_q, char_valid_d;
    logic [7:0]         char_code_q, char_code_d;
    logic               char_err_q, char_err_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   char_cnt_q, char_cnt_d;

    logic               blank_s;
    logic               timeout_s;
    logic               gap_viol_s;
    logic               last_col_s;
    logic [8:0]         lookup_s;

    assign blank_s    = (line == 5'h00);
    assign last_col_s = (state_q == ST_COLLECT) && col_valid && (col_cnt_q == 3'd3);
    assign timeout_s  = (state_q == ST_COLLECT) && !col_valid &&
                        (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1));
    assign gap_viol_s = (state_q == ST_GAP) && col_valid && !blank_s;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            glyph_q      <= 20'h00000;
            col_cnt_q    <= 3'd0;
            idle_cnt_q   <= '0;
            match_q      <= 1'b0;
            char_valid_q <= 1'b0;
            char_code_q  <= 8'h00;
            char_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            char_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            glyph_q      <= glyph_d;
            col_cnt_q    <= col_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            match_q      <= match_d;
            char_valid_q <= char_valid_d;
            char_code_q  <= char_code_d;
            char_err_q   <= char_err_d;
            frame_err_q  <= frame_err_d;
            char_cnt_q   <= char_cnt_d;
        end
    end

    // Next-state logic of the framing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (col_valid && !blank_s) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (last_col_s) begin
                    state_d = ST_GAP;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_GAP: begin
                if (col_valid && blank_s) begin
                    state_d = ST_IDLE;
                end else if (gap_viol_s) begin
                    state_d = ST_RESYNC;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_RESYNC: begin
                if (col_valid && blank_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESYNC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Column shift register, column counter, inter-strobe idle counter and match strobe.
    always_comb begin
        glyph_d    = glyph_q;
        col_cnt_d  = col_cnt_q;
        idle_cnt_d = '0;
        match_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (col_valid && !blank_s) begin
                    glyph_d   = {15'h0000, line};
                    col_cnt_d = 3'd1;
                end else begin
                    col_cnt_d = 3'd0;
                end
            end
            ST_COLLECT: begin
                if (col_valid) begin
                    glyph_d = {glyph_q[14:0], line};
                    if (col_cnt_q == 3'd3) begin
                        col_cnt_d = 3'd0;
                        match_d   = 1'b1;
                    end else begin
                        col_cnt_d = col_cnt_q + 3'd1;
                    end
                end else if (timeout_s) begin
                    glyph_d   = 20'h00000;
                    col_cnt_d = 3'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: begin
                col_cnt_d = 3'd0;
            end
        endcase
    end

    // Registered result outputs: decode one cycle after the 4th column, error pulses.
    always_comb begin
        lookup_s     = font_lookup(glyph_q);
        char_valid_d = match_q;
        frame_err_d  = gap_viol_s || timeout_s;
        if (match_q) begin
            char_code_d = lookup_s[7:0];
            char_err_d  = lookup_s[8];
        end else begin
            char_code_d = char_code_q;
            char_err_d  = 1'b0;
        end
        if (match_q && !lookup_s[8]) begin
            char_cnt_d = char_cnt_q + CNT_W'(1);
        end else begin
            char_cnt_d = char_cnt_q;
        end
    end

    assign char_valid = char_valid_q;
    assign char_code  = char_code_q;
    assign char_err   = char_err_q;
    assign frame_err  = frame_err_q;
    assign char_cnt   = char_cnt_q;

endmodule

// File: tb/tb_banner_glyph_decoder.sv
// Bench for banner_glyph_decoder: directed scenarios plus random column streams,
// checked every cycle against a queue-based reference model.
module tb_banner_glyph_decoder;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] line = 5'h00;
    logic       col_valid = 1'b0;

    logic       cv0, ce0, fe0;
    logic [7:0] cc0;
    logic [7:0] cnt0;
    logic       cv1, ce1, fe1;
    logic [7:0] cc1;
    logic [1:0] cnt1;

    banner_glyph_decoder #(.TIMEOUT_CYC(TO), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .line(line), .col_valid(col_valid),
        .char_valid(cv0), .char_code(cc0), .char_err(ce0), .frame_err(fe0), .char_cnt(cnt0));

    banner_glyph_decoder #(.TIMEOUT_CYC(TO), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .line(line), .col_valid(col_valid),
        .char_valid(cv1), .char_code(cc1), .char_err(ce1), .frame_err(fe1), .char_cnt(cnt1));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Font table: columns leftmost first; ASCII alongside.
    logic [4:0] font_cols [8][4];
    logic [7:0] font_chr  [8];

    // Reference model state
    int         m_mode = 0;            // 0 idle, 1 collecting, 2 awaiting gap, 3 resync
    logic [4:0] m_cols[$];
    logic [4:0] m_g[4];
    int         m_idle = 0;
    bit         m_pend = 1'b0;
    bit         e_valid = 1'b0, e_err = 1'b0, e_ferr = 1'b0;
    logic [7:0] e_code = 8'h00;
    int         e_cnt = 0;

    function automatic logic [8:0] ref_decode();
        for (int f = 0; f < 8; f++) begin
            bit hit = 1'b1;
            for (int c = 0; c < 4; c++) if (font_cols[f][c] != m_g[c]) hit = 1'b0;
            if (hit) return {1'b0, font_chr[f]};
        end
        return {1'b1, 8'h3F};
    endfunction

    // Model: what the outputs must be after each rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            logic [8:0] d;
            e_valid = 1'b0; e_err = 1'b0; e_ferr = 1'b0;
            if (m_pend) begin
                d = ref_decode();
                e_valid = 1'b1; e_code = d[7:0]; e_err = d[8];
                if (!d[8]) e_cnt++;
                m_pend = 1'b0;
            end
            case (m_mode)
                0: if (col_valid && line != 5'h00) begin
                       m_cols.delete(); m_cols.push_back(line); m_idle = 0; m_mode = 1;
                   end
                1: if (col_valid) begin
                       m_cols.push_back(line); m_idle = 0;
                       if (m_cols.size() == 4) begin
                           for (int i = 0; i < 4; i++) m_g[i] = m_cols[i];
                           m_pend = 1'b1; m_cols.delete(); m_mode = 2;
                       end
                   end else begin
                       m_idle++;
                       if (m_idle == TO) begin
                           e_ferr = 1'b1; m_cols.delete(); m_idle = 0; m_mode = 0;
                       end
                   end
                2: if (col_valid) begin
                       if (line == 5'h00) m_mode = 0;
                       else begin e_ferr = 1'b1; m_mode = 3; end
                   end
                3: if (col_valid && line == 5'h00) m_mode = 0;
                default: m_mode = 0;
            endcase
        end
    end

    // Model reset.
    always @(negedge rst_n) begin
        m_mode = 0; m_cols.delete(); m_idle = 0; m_pend = 1'b0;
        e_valid = 1'b0; e_err = 1'b0; e_ferr = 1'b0; e_code = 8'h00; e_cnt = 0;
    end

    // Observation log for directed scenarios.
    logic [7:0] obs[$];
    logic [1:0] obs_cnt1[$];
    int fcount = 0, ecount = 0;

    // Compare process: both instances against the model on every falling edge.
    always @(negedge clk) begin
        chk("char_valid", {31'd0, cv0}, {31'd0, e_valid});
        chk("char_code",  {24'd0, cc0}, {24'd0, e_code});
        chk("char_err",   {31'd0, ce0}, {31'd0, e_err});
        chk("frame_err",  {31'd0, fe0}, {31'd0, e_ferr});
        chk("char_cnt",   {24'd0, cnt0}, e_cnt % 256);
        chk("w2_valid",   {31'd0, cv1}, {31'd0, e_valid});
        chk("w2_code",    {24'd0, cc1}, {24'd0, e_code});
        chk("w2_cnt",     {30'd0, cnt1}, e_cnt % 4);
        if (cv0) obs.push_back(cc0);
        if (cv1) obs_cnt1.push_back(cnt1);
        if (fe0) fcount++;
        if (ce0) ecount++;
    end

    task automatic clr_obs();
        obs.delete(); obs_cnt1.delete(); fcount = 0; ecount = 0;
    endtask

    task automatic col(input logic [4:0] c, input int sp);
        line = c; col_valid = 1'b1;
        @(posedge clk); #1;
        col_valid = 1'b0; line = 5'($urandom);
        repeat (sp - 1) begin @(posedge clk); #1; end
    endtask

    task automatic glyph_cols(input int f, input int sp);
        for (int i = 0; i < 4; i++) col(font_cols[f][i], sp);
    endtask

    task automatic glyph(input int f, input int sp);
        glyph_cols(f, sp);
        col(5'h00, sp);
    endtask

    task automatic settle();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, cv0}, 32'd0);
        chk({tag, "_code"},  {24'd0, cc0}, 32'd0);
        chk({tag, "_err"},   {31'd0, ce0}, 32'd0);
        chk({tag, "_ferr"},  {31'd0, fe0}, 32'd0);
        chk({tag, "_cnt"},   {24'd0, cnt0}, 32'd0);
        chk({tag, "_cnt2"},  {30'd0, cnt1}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_obs();
    endtask

    localparam int S_ = 0, R_ = 1, E_ = 2, K_ = 3, A_ = 4, N_ = 5, T_ = 6, H_ = 7;

    initial begin
        logic [7:0] exp_codes [9];
        logic [1:0] exp_wrap [5];
        int seq [9];
        int k;

        font_cols[S_] = '{5'h17, 5'h15, 5'h15, 5'h1D}; font_chr[S_] = 8'h53;
        font_cols[R_] = '{5'h1F, 5'h05, 5'h0D, 5'h12}; font_chr[R_] = 8'h52;
        font_cols[E_] = '{5'h1F, 5'h15, 5'h15, 5'h11}; font_chr[E_] = 8'h45;
        font_cols[K_] = '{5'h1F, 5'h04, 5'h0A, 5'h11}; font_chr[K_] = 8'h4B;
        font_cols[A_] = '{5'h1E, 5'h05, 5'h05, 5'h1E}; font_chr[A_] = 8'h41;
        font_cols[N_] = '{5'h1F, 5'h02, 5'h04, 5'h1F}; font_chr[N_] = 8'h4E;
        font_cols[T_] = '{5'h01, 5'h1F, 5'h01, 5'h01}; font_chr[T_] = 8'h54;
        font_cols[H_] = '{5'h1F, 5'h04, 5'h04, 5'h1F}; font_chr[H_] = 8'h48;
        exp_codes = '{8'h53, 8'h52, 8'h45, 8'h45, 8'h4B, 8'h41, 8'h4E, 8'h54, 8'h48};
        exp_wrap  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        seq       = '{S_, R_, E_, E_, K_, A_, N_, T_, H_};

        repeat (3) @(posedge clk);
        #1 check_zero("init");
        rst_n = 1'b1;
        clr_obs();

        // SREEKANTH stream, col_valid every 2 cycles
        for (int i = 0; i < 9; i++) glyph(seq[i], 2);
        settle();
        chk("srk_count", obs.size(), 32'd9);
        for (int i = 0; i < 9; i++)
            if (i < obs.size()) chk("srk_code", {24'd0, obs[i]}, {24'd0, exp_codes[i]});
        chk("srk_errs", ecount, 32'd0);
        chk("srk_cnt", {24'd0, cnt0}, 32'd9);

        // Unknown glyph
        clr_obs();
        for (int i = 0; i < 4; i++) col(5'h1F, 1);
        col(5'h00, 1);
        settle();
        chk("unk_count", obs.size(), 32'd1);
        if (obs.size() > 0) chk("unk_code", {24'd0, obs[0]}, 32'h3F);
        chk("unk_err", ecount, 32'd1);
        chk("unk_cnt", {24'd0, cnt0}, 32'd9);

        // Gap violation
        clr_obs();
        glyph_cols(H_, 1);
        col(5'h1F, 1); col(5'h1F, 1); col(5'h00, 1);
        glyph(E_, 1);
        settle();
        chk("gap_count", obs.size(), 32'd2);
        if (obs.size() > 1) begin
            chk("gap_h", {24'd0, obs[0]}, 32'h48);
            chk("gap_e", {24'd0, obs[1]}, 32'h45);
        end
        chk("gap_ferr", fcount, 32'd1);

        // Timeout
        clr_obs();
        col(5'h1F, 1); col(5'h05, 1);
        k = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (fe0) begin k = i; break; end
        end
        chk("to_cycle", k, TO);
        settle();
        chk("to_novalid", obs.size(), 32'd0);
        glyph(T_, 1);
        settle();
        chk("to_t_count", obs.size(), 32'd1);
        if (obs.size() > 0) chk("to_t_code", {24'd0, obs[0]}, 32'h54);

        // Async reset mid-glyph
        col(font_cols[A_][0], 1); col(font_cols[A_][1], 1);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_obs();
        repeat (4) begin @(posedge clk); #1; end
        chk("midrst_quiet", obs.size(), 32'd0);
        glyph(K_, 1);
        settle();
        chk("midrst_k_count", obs.size(), 32'd1);
        if (obs.size() > 0) chk("midrst_k_code", {24'd0, obs[0]}, 32'h4B);
        chk("midrst_cnt", {24'd0, cnt0}, 32'd1);

        // Counter wrap on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) glyph(E_, 1);
        settle();
        chk("wrap_count", obs_cnt1.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < obs_cnt1.size()) chk("wrap_seq", {30'd0, obs_cnt1[i]}, {30'd0, exp_wrap[i]});

        // Random streams
        for (int it = 0; it < 80; it++) begin
            int r, sp, nb;
            r  = $urandom_range(0, 9);
            sp = $urandom_range(1, 3);
            if (r < 6) begin
                glyph_cols($urandom_range(0, 7), sp);
                nb = $urandom_range(0, 2);
                repeat (nb) col(5'h00, sp);
            end else if (r < 8) begin
                for (int i = 0; i < 4; i++) col(5'($urandom), sp);
                col(5'h00, sp);
            end else if (r == 8) begin
                nb = $urandom_range(1, 3);
                col(5'h1F, sp);
                repeat (nb - 1) col(5'($urandom), sp);
                repeat ($urandom_range(55, 70)) begin @(posedge clk); #1; end
                col(5'h00, 1);
            end else begin
                repeat ($urandom_range(1, 3)) col(5'($urandom), sp);
            end
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
